// File: rtl/texture_uploader_pkg.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// texture_uploader_pkg
//
// Purpose:
//   Shared video defines for the 64-tile, 8x8, 3bpp texture store.
//   The CPU-side uploader and the video fetch side both use these definitions,
//   so the store address layout is defined in one place only.
//
// Contents:
//   TEXEL_W, TEX_ADDR_W        texel width and store address width
//   TILE_DIM, TILE_COUNT       tile geometry
//   *_LSB / *_W                field positions in the store address and in the
//                              iomem word address
//   state_t                    uploader FSM states
//   make_tex_addr()            packs {tile, row, col} into a store address
// -----------------------------------------------------------------------------
package texture_uploader_pkg;

  // Texture store geometry
  localparam int TEXEL_W    = 3;
  localparam int TEX_ADDR_W = 12;
  localparam int TILE_DIM   = 8;
  localparam int TILE_COUNT = 64;

  // Store address = {tile[5:0], row[2:0], col[2:0]}
  localparam int TILE_W       = 6;
  localparam int ROW_W        = 3;
  localparam int COL_W        = 3;
  localparam int TEX_COL_LSB  = 0;
  localparam int TEX_ROW_LSB  = TEX_COL_LSB + COL_W;
  localparam int TEX_TILE_LSB = TEX_ROW_LSB + ROW_W;

  // iomem word address: [10:5] = tile, [4:2] = row; all other bits alias
  localparam int IOMEM_ROW_LSB  = 2;
  localparam int IOMEM_TILE_LSB = IOMEM_ROW_LSB + ROW_W;

  // iomem bus widths
  localparam int IOMEM_ADDR_W = 32;
  localparam int IOMEM_DATA_W = 32;
  localparam int IOMEM_STRB_W = 4;

  // Each texel column occupies one nibble of the write word
  localparam int NIBBLE_W = 4;

  // Last column of a tile row
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(TILE_DIM - 1);

  typedef logic [TILE_W-1:0]     tile_t;
  typedef logic [ROW_W-1:0]      row_t;
  typedef logic [COL_W-1:0]      col_t;
  typedef logic [TEXEL_W-1:0]    texel_t;
  typedef logic [TEX_ADDR_W-1:0] tex_addr_t;

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  // Pack tile/row/col into a store address
  function automatic tex_addr_t make_tex_addr(input tile_t tile, input row_t row, input col_t col);
    return {tile, row, col};
  endfunction

endpackage

// File: rtl/texture_uploader_if.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// texture_uploader_if
//
// Purpose:
//   picosoc iomem request/response bundle as seen by a peripheral that has
//   already been selected by the parent's address decode.
//
// Signals:
//   valid  request present; held by the master until ready
//   ready  one-cycle acknowledge from the slave
//   wstrb  byte strobes; all-zero means a read
//   addr   word address
//   wdata  write data
//   rdata  read data, valid in the ready cycle
//
// Modports:
//   master  CPU / decoder side
//   slave   peripheral side (texture_uploader)
// -----------------------------------------------------------------------------
interface texture_uploader_if;
  import texture_uploader_pkg::*;

  logic                    valid;
  logic                    ready;
  logic [IOMEM_STRB_W-1:0] wstrb;
  logic [IOMEM_ADDR_W-1:0] addr;
  logic [IOMEM_DATA_W-1:0] wdata;
  logic [IOMEM_DATA_W-1:0] rdata;

  modport master (
    output valid,
    output wstrb,
    output addr,
    output wdata,
    input  ready,
    input  rdata
  );

  modport slave (
    input  valid,
    input  wstrb,
    input  addr,
    input  wdata,
    output ready,
    output rdata
  );

endinterface

// File: rtl/texture_uploader.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// texture_uploader
//
// Purpose:
//   CPU-side writer for the texture store. A posted iomem write carries one
//   8-texel tile row; the row is latched and serialised into the store write
//   port at one texel per clock. Reads return a busy status word for polling.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   iomem      iomem slave (valid/ready/wstrb/addr/wdata/rdata)
//   tex_wen    store write enable
//   tex_waddr  store write address {tile, row, col}
//   tex_wdata  store write data (one texel)
//   busy       high while a row is latched or being drained
//
// Timing:
//   A write accepted at edge N gives ready at N+1 together with texel 0;
//   texel i is presented at N+1+i and the FSM is idle again at N+9.
//   Writes arriving while draining are back-pressured; reads are answered in
//   either state and never disturb the drain. All outputs are registered.
// -----------------------------------------------------------------------------
module texture_uploader
  import texture_uploader_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  texture_uploader_if.slave        iomem,
  output logic                     tex_wen,
  output tex_addr_t                tex_waddr,
  output texel_t                   tex_wdata,
  output logic                     busy
);

  // FSM state and column counter
  state_t state;
  state_t state_next;
  col_t   col;
  col_t   col_next;

  // Latched tile row: position, lane strobes and colour bits of every column
  tile_t                   row_tile;
  row_t                    row_row;
  logic [IOMEM_STRB_W-1:0] row_wstrb;
  texel_t                  row_texels [TILE_DIM];

  // Next values of the registered outputs
  logic                    load_row;
  logic                    ready_next;
  logic [IOMEM_DATA_W-1:0] rdata_next;
  logic                    wen_next;
  tex_addr_t               waddr_next;
  texel_t                  wdata_next;
  logic                    busy_next;

  // Request decode
  logic  accept;
  logic  is_write;
  tile_t req_tile;
  row_t  req_row;

  // A request that was acknowledged last cycle may still be held by the
  // master this cycle, so it is only a new request when ready is low. This
  // keeps ready to one cycle and stops a write and a read acknowledge from
  // ever landing back to back.
  always_comb begin
    accept   = iomem.valid && !iomem.ready;
    is_write = |iomem.wstrb;
    req_tile = iomem.addr[IOMEM_TILE_LSB +: TILE_W];
    req_row  = iomem.addr[IOMEM_ROW_LSB +: ROW_W];
  end

  // State register; reset wins over any request in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and next-output logic. The outputs are registered, so this
  // block computes what the store port must show in the *following* cycle:
  // on acceptance that is texel 0 straight from the bus, and in DRAIN it is
  // texel col+1 from the latched row. Address and data only move when the
  // texel is actually written, so they hold across skipped byte lanes.
  always_comb begin
    state_next = state;
    col_next   = col;
    load_row   = 1'b0;
    ready_next = 1'b0;
    rdata_next = '0;
    wen_next   = 1'b0;
    waddr_next = tex_waddr;
    wdata_next = tex_wdata;
    busy_next  = busy;

    case (state)
      IDLE: begin
        if (accept) begin
          ready_next = 1'b1;
          if (is_write) begin
            load_row   = 1'b1;
            state_next = DRAIN;
            col_next   = '0;
            busy_next  = 1'b1;
            wen_next   = iomem.wstrb[0];
            if (iomem.wstrb[0]) begin
              waddr_next = make_tex_addr(req_tile, req_row, '0);
              wdata_next = iomem.wdata[TEXEL_W-1:0];
            end
          end else begin
            rdata_next = {{(IOMEM_DATA_W-1){1'b0}}, busy};
          end
        end
      end

      DRAIN: begin
        // Status reads are served alongside the drain; writes wait.
        if (accept && !is_write) begin
          ready_next = 1'b1;
          rdata_next = {{(IOMEM_DATA_W-1){1'b0}}, busy};
        end

        if (col == COL_LAST) begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end else begin
          col_next = col + 3'd1;
          // Each byte lane covers two adjacent texel columns.
          wen_next = row_wstrb[col_next[COL_W-1:1]];
          if (wen_next) begin
            waddr_next = make_tex_addr(row_tile, row_row, col_next);
            wdata_next = row_texels[col_next];
          end
        end
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // Registered outputs and column counter. Reset clears the store port at
  // once, so a reset mid-row drops the remaining texels.
  always_ff @(posedge clk) begin
    if (reset) begin
      col          <= '0;
      iomem.ready  <= 1'b0;
      iomem.rdata  <= '0;
      tex_wen      <= 1'b0;
      tex_waddr    <= '0;
      tex_wdata    <= '0;
      busy         <= 1'b0;
    end else begin
      col          <= col_next;
      iomem.ready  <= ready_next;
      iomem.rdata  <= rdata_next;
      tex_wen      <= wen_next;
      tex_waddr    <= waddr_next;
      tex_wdata    <= wdata_next;
      busy         <= busy_next;
    end
  end

  // Row latch. Only the three colour bits of each nibble are kept; bit 3 of
  // every nibble is ignored by the store format.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_tile  <= '0;
      row_row   <= '0;
      row_wstrb <= '0;
      for (int i = 0; i < TILE_DIM; i++) begin
        row_texels[i] <= '0;
      end
    end else if (load_row) begin
      row_tile  <= req_tile;
      row_row   <= req_row;
      row_wstrb <= iomem.wstrb;
      for (int i = 0; i < TILE_DIM; i++) begin
        row_texels[i] <= iomem.wdata[NIBBLE_W*i +: TEXEL_W];
      end
    end
  end

endmodule

// File: tb/tb_texture_uploader.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_texture_uploader
//
// Purpose:
//   Self-checking bench for texture_uploader. A cycle-indexed model predicts,
//   from the transaction rules alone, when each request is acknowledged and
//   which texel the store port shows in every cycle; a compare process checks
//   the DUT against it on every falling edge. A store mirror plus literal
//   expectations pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_texture_uploader;

  localparam int MAXC = 2048;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tex_wen;
  logic [11:0] tex_waddr;
  logic [2:0]  tex_wdata;
  logic        busy;

  texture_uploader_if bus ();

  texture_uploader dut (
    .clk       (clk),
    .reset     (reset),
    .iomem     (bus),
    .tex_wen   (tex_wen),
    .tex_waddr (tex_waddr),
    .tex_wdata (tex_wdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Cycle k is the interval following the k-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;
  bit check_en = 1'b0;

  // Model: expected outputs per cycle
  bit          exp_wen    [MAXC];
  logic [11:0] exp_addr   [MAXC];
  logic [2:0]  exp_data   [MAXC];
  bit          exp_busy   [MAXC];
  bit          exp_ready  [MAXC];
  bit          exp_isread [MAXC];
  bit          exp_rdata  [MAXC];
  bit          exp_zero   [MAXC];
  int          idle_from = 0;
  logic [11:0] hold_addr = '0;
  logic [2:0]  hold_data = '0;

  // Store mirror: -1 means never written
  int store [4096];

  always @(posedge clk) begin
    if (tex_wen) store[tex_waddr] = int'(tex_wdata);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
    end
  endtask

  // Reset sampled at the end of cycle k: everything cleared from k+1 on.
  function automatic void modelReset(input int k);
    for (int c = k + 1; c < MAXC; c++) begin
      exp_wen[c]    = 1'b0;
      exp_busy[c]   = 1'b0;
      exp_ready[c]  = 1'b0;
      exp_isread[c] = 1'b0;
      exp_rdata[c]  = 1'b0;
    end
    exp_zero[k+1] = 1'b1;
    idle_from     = k + 1;
  endfunction

  // Write first driven in cycle k: accepted at the end of the first idle,
  // non-ready cycle a; ready at a+1; texel i at a+1+i; idle again at a+9.
  function automatic void modelWrite(input int k, input logic [31:0] addr, input logic [31:0] data,
                                     input logic [3:0] strb);
    int a;
    int tile;
    int row;
    int c;
    a = (k > idle_from) ? k : idle_from;
    if (exp_ready[a]) a++;
    tile = int'(addr[10:5]);
    row  = int'(addr[4:2]);
    exp_ready[a+1]  = 1'b1;
    exp_isread[a+1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      c = a + 1 + i;
      exp_busy[c] = 1'b1;
      exp_wen[c]  = strb[i/2];
      exp_addr[c] = 12'(tile * 64 + row * 8 + i);
      exp_data[c] = 3'(data >> (4 * i));
    end
    idle_from = a + 9;
  endfunction

  // Read first driven in cycle k: answered with the busy flag of its
  // acceptance cycle.
  function automatic void modelRead(input int k);
    int a;
    a = k;
    if (exp_ready[a]) a++;
    exp_ready[a+1]  = 1'b1;
    exp_isread[a+1] = 1'b1;
    exp_rdata[a+1]  = exp_busy[a];
  endfunction

  // Compare process
  always @(negedge clk) begin
    if (check_en && cyc < MAXC) begin
      if (exp_zero[cyc]) begin
        hold_addr = '0;
        hold_data = '0;
      end
      if (exp_wen[cyc]) begin
        hold_addr = exp_addr[cyc];
        hold_data = exp_data[cyc];
      end
      checkOutput("tex_wen",   {31'b0, tex_wen},   {31'b0, exp_wen[cyc]});
      checkOutput("tex_waddr", {20'b0, tex_waddr}, {20'b0, hold_addr});
      checkOutput("tex_wdata", {29'b0, tex_wdata}, {29'b0, hold_data});
      checkOutput("busy",      {31'b0, busy},      {31'b0, exp_busy[cyc]});
      checkOutput("ready",     {31'b0, bus.ready}, {31'b0, exp_ready[cyc]});
      if (exp_ready[cyc] && exp_isread[cyc]) begin
        checkOutput("rdata", bus.rdata, {31'b0, exp_rdata[cyc]});
      end
    end
  end

  // Issues one request from a rising edge + 1 point, holds it until ready,
  // drops it in the cycle after ready and returns there. Optionally pulses
  // reset in the same cycle the request first appears.
  task automatic applyStimulus(input bit is_write, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input bit with_reset, output logic [31:0] rd);
    int k;
    bit seen;
    bit got;
    k    = cyc;
    rd   = '0;
    got  = 1'b0;
    seen = 1'b0;
    if (with_reset) begin
      reset = 1'b1;
      modelReset(k);
    end
    if (is_write) modelWrite(k, addr, data, strb);
    else          modelRead(k);
    bus.valid = 1'b1;
    bus.addr  = addr;
    bus.wdata = data;
    bus.wstrb = is_write ? strb : 4'b0000;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      seen = bus.ready;
      if (seen) rd = bus.rdata;
      @(posedge clk);
      #1;
      reset = 1'b0;
      if (seen) begin
        bus.valid = 1'b0;
        bus.wstrb = 4'b0000;
        got = 1'b1;
      end
    end
    if (!got) begin
      checks++;
      fails++;
      $display("[TB] FAIL handshake_timeout at cycle %0d: got no ready, expected ready within 40 cycles", cyc);
      bus.valid = 1'b0;
    end
  endtask

  task automatic waitIdle();
    repeat (10) @(posedge clk);
    #1;
  endtask

  logic [31:0] rd;
  int          k0;

  initial begin
    for (int i = 0; i < 4096; i++) store[i] = -1;
    bus.valid = 1'b0;
    bus.wstrb = 4'b0000;
    bus.addr  = '0;
    bus.wdata = '0;
    reset     = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", {31'b0, bus.ready}, 32'd0);
    checkOutput("rst_rdata", bus.rdata, 32'd0);
    checkOutput("rst_wen",   {31'b0, tex_wen}, 32'd0);
    checkOutput("rst_waddr", {20'b0, tex_waddr}, 32'd0);
    checkOutput("rst_wdata", {29'b0, tex_wdata}, 32'd0);
    checkOutput("rst_busy",  {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    check_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Tile 5 row 3, full strobes; upper address bits alias away
    $display("[TB] write tile 5 row 3");
    applyStimulus(1'b1, 32'h0000_08AC, 32'h7654_3210, 4'hF, 1'b0, rd);
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("t1_last_wen",   {31'b0, tex_wen}, 32'd1);
    checkOutput("t1_last_waddr", {20'b0, tex_waddr}, 32'h15F);
    checkOutput("t1_last_wdata", {29'b0, tex_wdata}, 32'd7);
    checkOutput("t1_last_busy",  {31'b0, busy}, 32'd1);
    @(negedge clk);
    checkOutput("t1_end_busy",   {31'b0, busy}, 32'd0);
    checkOutput("t1_end_wen",    {31'b0, tex_wen}, 32'd0);
    checkOutput("t1_hold_waddr", {20'b0, tex_waddr}, 32'h15F);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) checkOutput("t1_store", store[12'h158 + i], i);

    // Read in IDLE
    $display("[TB] status read while idle");
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, rd);
    checkOutput("idle_read_rdata", rd, 32'd0);

    // All-ones data: bit 3 of each nibble dropped
    $display("[TB] write tile 63 row 7 all ones");
    applyStimulus(1'b1, 32'h0000_07FC, 32'hFFFF_FFFF, 4'hF, 1'b0, rd);
    waitIdle();
    for (int i = 0; i < 8; i++) checkOutput("ones_store", store[12'hFF8 + i], 7);

    // Partial strobes: lanes 0 and 2 only
    $display("[TB] write tile 0 row 0 wstrb 0101");
    applyStimulus(1'b1, 32'h0000_0000, 32'h7654_3210, 4'b0101, 1'b0, rd);
    waitIdle();
    checkOutput("strb_col0", store[0], 0);
    checkOutput("strb_col1", store[1], 1);
    checkOutput("strb_col2", store[2], -1);
    checkOutput("strb_col3", store[3], -1);
    checkOutput("strb_col4", store[4], 4);
    checkOutput("strb_col5", store[5], 5);
    checkOutput("strb_col6", store[6], -1);
    checkOutput("strb_col7", store[7], -1);

    // Back-to-back writes: the second is held from N+2, ready at N+10
    $display("[TB] back-to-back writes tile 1 rows 2 and 3");
    k0 = cyc;
    applyStimulus(1'b1, 32'h0000_0028, 32'h0123_4567, 4'hF, 1'b0, rd);
    applyStimulus(1'b1, 32'h0000_002C, 32'h89AB_CDEF, 4'hF, 1'b0, rd);
    checkOutput("b2b_latency", cyc - k0, 32'd11);
    waitIdle();
    for (int i = 0; i < 8; i++) begin
      checkOutput("b2b_store_a", store[12'h050 + i], 7 - i);
      checkOutput("b2b_store_b", store[12'h058 + i], 7 - i);
    end

    // Status read while draining, issued at N+3
    $display("[TB] status read while draining");
    applyStimulus(1'b1, 32'h0000_0040, 32'h7654_3210, 4'hF, 1'b0, rd);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, rd);
    checkOutput("drain_read_rdata", rd, 32'd1);
    waitIdle();
    for (int i = 0; i < 8; i++) checkOutput("drain_read_store", store[12'h080 + i], i);

    // Reset during the drain, asserted in cycle N+4
    $display("[TB] reset mid-drain");
    applyStimulus(1'b1, 32'h0000_0124, 32'h7654_3210, 4'hF, 1'b0, rd);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    modelReset(cyc);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_wen",  {31'b0, tex_wen}, 32'd0);
    checkOutput("rst_mid_busy", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
    waitIdle();
    checkOutput("rst_mid_col0", store[12'h248], 0);
    for (int i = 4; i < 8; i++) checkOutput("rst_mid_dropped", store[12'h248 + i], -1);

    // Normal write after the reset
    $display("[TB] write after reset");
    applyStimulus(1'b1, 32'h0000_0140, 32'h0123_4567, 4'hF, 1'b0, rd);
    waitIdle();
    checkOutput("post_rst_col0", store[12'h280], 7);
    checkOutput("post_rst_col7", store[12'h287], 0);

    // Reset and request together: reset wins, request accepted one cycle later
    $display("[TB] reset coinciding with a write");
    k0 = cyc;
    applyStimulus(1'b1, 32'h0000_0170, 32'h3333_3333, 4'hF, 1'b1, rd);
    checkOutput("rst_valid_latency", cyc - k0, 32'd3);
    waitIdle();
    checkOutput("rst_valid_store", store[12'h2E0], 3);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog at cycle %0d: got no end of test, expected completion", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
